// File: rtl/multi_edge_detector_if.sv
// multi_edge_detector_if: channel I/O bundle for multi_edge_detector
// master drives I, mode, clear, irq_en; slave returns edge_pulse, edge_dir, level, flag, irq
interface multi_edge_detector_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0]   I;
  logic [2*NUM_CH-1:0] mode;
  logic [NUM_CH-1:0]   clear;
  logic [NUM_CH-1:0]   irq_en;
  logic [NUM_CH-1:0]   edge_pulse;
  logic [NUM_CH-1:0]   edge_dir;
  logic [NUM_CH-1:0]   level;
  logic [NUM_CH-1:0]   flag;
  logic                irq;
  modport master (output I, mode, clear, irq_en, input edge_pulse, edge_dir, level, flag, irq);
  modport slave (input I, mode, clear, irq_en, output edge_pulse, edge_dir, level, flag, irq);
endinterface

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel synchroniser, debounce FSM, mode-gated edge pulses, sticky flags, irq
// clk: rising-edge clock; reset: async active-low; bus: slave side of multi_edge_detector_if
module multi_edge_detector #(
  parameter int NUM_CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  multi_edge_detector_if.slave bus
);
  localparam int CW = $clog2(SYNC_STAGES + DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] INIT_END = CW'(SYNC_STAGES + DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] PEND_END = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {INIT, STABLE, PEND} state_t;
  logic [NUM_CH-1:0] pulse_v, dir_v, level_v, flag_v;
  logic irq_q, irq_d;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d, pulse_q, pulse_d, dir_q, dir_d, flag_q, flag_d, acc, s;
    assign s = sync_q[SYNC_STAGES-1];
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], bus.I[c]};
      state_d = state_q;
      cnt_d = cnt_q;
      level_d = level_q;
      acc = 1'b0;
      case (state_q)
        INIT: begin
          if (cnt_q == INIT_END) begin
            level_d = s;
            cnt_d = '0;
            state_d = STABLE;
          end else cnt_d = cnt_q + CW'(1);
        end
        STABLE: begin
          if (s != level_q) begin
            if (DEBOUNCE_CYCLES == 1) acc = 1'b1;
            else begin
              state_d = PEND;
              cnt_d = CW'(1);
            end
          end
        end
        PEND: begin
          if (s == level_q) begin
            state_d = STABLE;
            cnt_d = '0;
          end else if (cnt_q == PEND_END) acc = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
        default: state_d = INIT;
      endcase
      if (acc) begin
        level_d = ~level_q;
        state_d = STABLE;
        cnt_d = '0;
      end
      // new level is ~level_q: rising uses mode bit 0, falling uses mode bit 1
      pulse_d = acc & (level_q ? bus.mode[2*c+1] : bus.mode[2*c]);
      dir_d = acc & ~level_q;
      // set from the visible pulse so a clear in the pulse cycle loses
      flag_d = pulse_q | (flag_q & ~bus.clear[c]);
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
        state_q <= INIT;
        cnt_q <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        dir_q <= 1'b0;
        flag_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        state_q <= state_d;
        cnt_q <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
        dir_q <= dir_d;
        flag_q <= flag_d;
      end
    end
    assign pulse_v[c] = pulse_q;
    assign dir_v[c] = dir_q;
    assign level_v[c] = level_q;
    assign flag_v[c] = flag_q;
  end
  always_comb irq_d = |(flag_v & bus.irq_en);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign bus.edge_pulse = pulse_v;
  assign bus.edge_dir = dir_v;
  assign bus.level = level_v;
  assign bus.flag = flag_v;
  assign bus.irq = irq_q;
endmodule
